// File: rtl/load_store_unit.sv
// load_store_unit: core data-port sequencer with byte enables, load extension and bus timeout.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned halfword/word requests.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t      state, state_n;
  logic [31:0] cnt, l_addr, l_wd, addr, wd;
  logic [2:0]  l_size, size;
  logic        l_we, we, rej, active, tmo, done;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  // While waiting the core holds its request, but the bus sees the captured copy.
  assign we   = state == S_WAIT ? l_we : core_we_i;
  assign size = state == S_WAIT ? l_size : core_size_i;
  assign addr = state == S_WAIT ? l_addr : core_addr_i;
  assign wd   = state == S_WAIT ? l_wd : core_wd_i;
`ifdef LSU_MISALIGN_CHECK_EN
  assign rej = ~rst_i & state == S_IDLE & core_req_i &
               ((size[1:0] == 2'b01 & addr[0]) | (size[1] & addr[1:0] != 2'b00));
`else
  assign rej = 1'b0;
`endif
  assign active = ~rst_i & ((state == S_IDLE & core_req_i & ~rej) | state == S_WAIT);
  assign tmo    = TIMEOUT_CYCLES != 0 & state == S_WAIT & cnt == TIMEOUT_CYCLES;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      l_we   <= 1'b0;
      l_size <= '0;
      l_addr <= '0;
      l_wd   <= '0;
    end else begin
      state <= state_n;
      cnt   <= state_n == S_IDLE ? '0 : state == S_IDLE ? 32'd1 : cnt + 32'd1;
      if (state == S_IDLE && state_n == S_WAIT) begin
        l_we   <= core_we_i;
        l_size <= core_size_i;
        l_addr <= core_addr_i;
        l_wd   <= core_wd_i;
      end
    end
  end
  always_comb begin
    state_n = state;
    if (state == S_IDLE)
      state_n = active & ~mem_ready_i ? S_WAIT : S_IDLE;
    else
      state_n = mem_ready_i | tmo ? S_IDLE : S_WAIT;
  end
  always_comb begin
    mem_req_o    = active & ~tmo;
    mem_we_o     = mem_req_o & we;
    core_stall_o = active & ~mem_ready_i & ~tmo;
    core_err_o   = tmo;
    misalign_o   = rej;
    done         = mem_req_o & mem_ready_i;
    mem_addr_o   = mem_req_o ? {addr[31:2], 2'b00} : '0;
    mem_be_o     = ~mem_req_o ? 4'b0000 : size[1] ? 4'b1111 :
                   size[0] ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
    mem_wd_o     = ~mem_req_o ? '0 : size[1] ? wd : size[0] ? {2{wd[15:0]}} : {4{wd[7:0]}};
    byte_v       = mem_rd_i[{addr[1:0], 3'b000} +: 8];
    half_v       = addr[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    core_rd_o    = ~done ? '0 : size[1] ? mem_rd_i :
                   size[0] ? {{16{~size[2] & half_v[15]}}, half_v} :
                   {{24{~size[2] & byte_v[7]}}, byte_v};
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized transactions checked each cycle against a lane-arithmetic model.
module tb_load_store_unit;
  localparam int TMO = 4;
  logic        clk_i = 0, rst_i = 1, core_req_i = 0, core_we_i = 0, mem_ready_i = 0;
  logic [2:0]  core_size_i = 0;
  logic [31:0] core_addr_i = 0, core_wd_i = 0, mem_rd_i = 0;
  logic [31:0] core_rd_o, mem_addr_o, mem_wd_o;
  logic [3:0]  mem_be_o;
  logic        core_stall_o, core_err_o, misalign_o, mem_req_o, mem_we_o;
  int errors = 0, checks = 0, waited = 0;
  always #5 clk_i = ~clk_i;
  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
    .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .core_err_o(core_err_o),
    .misalign_o(misalign_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int nb(input logic [2:0] s);
    return (s == 3'd0 || s == 3'd4) ? 1 : (s == 3'd1 || s == 3'd5) ? 2 : 4;
  endfunction
  function automatic int off(input logic [2:0] s, input logic [31:0] a);
    return int'(a % 4) / nb(s) * nb(s);
  endfunction
  function automatic bit misal(input logic [2:0] s, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    return int'(a % 4) % nb(s) != 0;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [31:0] ebe(input logic [2:0] s, input logic [31:0] a);
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++) r[i] = i >= off(s, a) && i < off(s, a) + nb(s);
    return r;
  endfunction
  function automatic logic [31:0] ewd(input logic [2:0] s, input logic [31:0] d);
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb(s)) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] erd(input logic [2:0] s, input logic [31:0] a, input logic [31:0] w);
    int n = nb(s);
    logic [31:0] v = w >> (8 * off(s, a)), mask;
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if ((s == 3'd0 || s == 3'd1) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction
  // Model: a held request has been outstanding for 'waited' cycles; it times out at TMO.
  always @(negedge clk_i) begin
    logic rej, act, tmo, rq, dn;
    rej = !rst_i && core_req_i && waited == 0 && misal(core_size_i, core_addr_i);
    act = !rst_i && core_req_i && !rej;
    tmo = act && waited == TMO;
    rq  = act && !tmo;
    dn  = rq && mem_ready_i;
    chk("mem_req", 32'(mem_req_o), 32'(rq));
    chk("mem_we", 32'(mem_we_o), 32'(rq && core_we_i));
    chk("mem_addr", mem_addr_o, rq ? core_addr_i & ~32'd3 : 32'd0);
    chk("mem_be", 32'(mem_be_o), rq ? ebe(core_size_i, core_addr_i) : 32'd0);
    chk("mem_wd", mem_wd_o, rq ? ewd(core_size_i, core_wd_i) : 32'd0);
    chk("stall", 32'(core_stall_o), 32'(act && !mem_ready_i && !tmo));
    chk("err", 32'(core_err_o), 32'(tmo));
    chk("misalign", 32'(misalign_o), 32'(rej));
    chk("core_rd", core_rd_o, dn ? erd(core_size_i, core_addr_i, mem_rd_i) : 32'd0);
    waited = (act && !mem_ready_i && !tmo) ? waited + 1 : 0;
  end
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic xact(input bit w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d,
                      input int lat, input logic [31:0] rdw, output int stalls, output int errs,
                      output logic [31:0] rd, output logic [31:0] a0, output logic [31:0] be0,
                      output logic [31:0] wd0);
    int k;
    core_req_i = 1; core_we_i = w; core_size_i = s; core_addr_i = a; core_wd_i = d;
    mem_rd_i = rdw; stalls = 0; errs = 0; rd = 0;
    for (k = 0; k < 20; k++) begin
      mem_ready_i = k >= lat;
      #2;
      if (k == 0) begin a0 = mem_addr_o; be0 = 32'(mem_be_o); wd0 = mem_wd_o; end
      rd = core_rd_o;
      errs += int'(core_err_o);
      if (!core_stall_o) break;
      stalls++;
      cyc();
    end
    if (k == 20) chk("stall_bound", 32'(k), 32'd19);
    cyc();
    core_req_i = 0; mem_ready_i = 1'($urandom); mem_rd_i = $urandom;
  endtask
  initial begin
    int st, er;
    logic [31:0] rd, a0, be0, wd0;
    cyc();
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_stall", 32'(core_stall_o), 32'd0);
    rst_i = 0;
    cyc();
    xact(1, 3'd2, 32'h100, 32'hDEADBEEF, 3, 0, st, er, rd, a0, be0, wd0);
    chk("sw_stalls", 32'(st), 32'd3);
    chk("sw_be", be0, 32'hF);
    chk("sw_addr", a0, 32'h100);
    chk("sw_err", 32'(er), 32'd0);
    xact(0, 3'd0, 32'h203, 0, 0, 32'h80000000, st, er, rd, a0, be0, wd0);
    chk("lb_rd", rd, 32'hFFFFFF80);
    chk("lb_stalls", 32'(st), 32'd0);
    xact(0, 3'd4, 32'h203, 0, 0, 32'h80000000, st, er, rd, a0, be0, wd0);
    chk("lbu_rd", rd, 32'h00000080);
    xact(1, 3'd1, 32'h12, 32'h0000ABCD, 1, 0, st, er, rd, a0, be0, wd0);
    chk("sh_be", be0, 32'hC);
    chk("sh_wd", wd0, 32'hABCDABCD);
    xact(0, 3'd5, 32'h12, 0, 2, 32'h89AB5678, st, er, rd, a0, be0, wd0);
    chk("lhu_rd", rd, 32'h000089AB);
    xact(0, 3'd1, 32'h12, 0, 0, 32'h89AB5678, st, er, rd, a0, be0, wd0);
    chk("lh_rd", rd, 32'hFFFF89AB);
    xact(0, 3'd2, 32'h40, 0, 100, 32'h11111111, st, er, rd, a0, be0, wd0);
    chk("tmo_stalls", 32'(st), 32'd4);
    chk("tmo_err", 32'(er), 32'd1);
    chk("tmo_rd", rd, 32'd0);
    core_req_i = 1; core_we_i = 0; core_size_i = 3'd2; core_addr_i = 32'h40; mem_ready_i = 0;
    cyc();
    cyc();
    rst_i = 1;
    #1;
    chk("arst_req", 32'(mem_req_o), 32'd0);
    chk("arst_stall", 32'(core_stall_o), 32'd0);
    core_req_i = 0;
    cyc();
    rst_i = 0;
    cyc();
    xact(0, 3'd2, 32'h80, 0, 1, 32'hCAFEF00D, st, er, rd, a0, be0, wd0);
    chk("post_rst_rd", rd, 32'hCAFEF00D);
    chk("post_rst_stalls", 32'(st), 32'd1);
    xact(0, 3'd2, 32'h102, 0, 1, 32'h01020304, st, er, rd, a0, be0, wd0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("misal_addr", a0, 32'd0);
    chk("misal_stalls", 32'(st), 32'd0);
`else
    chk("misal_addr", a0, 32'h100);
    chk("misal_rd", rd, 32'h01020304);
`endif
    for (int t = 0; t < 400; t++) begin
      xact(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 6),
           $urandom, st, er, rd, a0, be0, wd0);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        mem_ready_i = 1'($urandom);
        cyc();
      end
    end
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
